mem_req_arbiter: RTL and testbench

- Shares the single DDR memory-controller user port (256-bit line, 26-bit line address) between two requesters, e.g. the Ethernet debug adapter (port 0) and the core refill path (port 1).
- Round-robin arbitration into one registered request stage.
- Tracks outstanding loads in an in-order tag FIFO and steers each load response back to the requester that issued it.
- Stores produce no response.

---
 rtl/mem_if_pkg.sv | 24 ++
 rtl/mem_req_arbiter_if.sv | 43 ++++
 rtl/mem_tag_fifo.sv | 48 ++++
 rtl/mem_req_arbiter.sv | 102 ++++++++++
 tb/tb_mem_req_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the DDR user-port arbiter: line geometry, requester ids
// and the request record.
package mem_if_pkg;

    localparam int MEM_ADDR_W  = 26;
    localparam int MEM_DATA_W  = 256;
    localparam int NUM_MEM_REQ = 2;

    typedef logic req_id_t;

    typedef struct packed {
        logic                  rw;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] data;
    } mem_req_t;

    function automatic logic [NUM_MEM_REQ-1:0] id_onehot(input req_id_t id);
        logic [NUM_MEM_REQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Requester-side and controller-side signals of the DDR user-port arbiter.
// The arb modport is the arbiter's view, client is the surrounding system's view.
interface mem_req_arbiter_if #(
    parameter int ADDR_W = mem_if_pkg::MEM_ADDR_W,
    parameter int DATA_W = mem_if_pkg::MEM_DATA_W
) ();
    import mem_if_pkg::*;

    logic [NUM_MEM_REQ-1:0]        req_val;
    logic [NUM_MEM_REQ-1:0]        req_rdy;
    logic [NUM_MEM_REQ-1:0]        req_rw;
    logic [NUM_MEM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_MEM_REQ*DATA_W-1:0] req_data;
    logic [NUM_MEM_REQ-1:0]        resp_val;
    logic [DATA_W-1:0]             resp_data;

    logic                          mem_req_val;
    logic                          mem_req_rdy;
    logic                          mem_req_rw;
    logic [ADDR_W-1:0]             mem_req_addr;
    logic [DATA_W-1:0]             mem_req_data;
    logic                          mem_resp_val;
    logic [DATA_W-1:0]             mem_resp_data;

    logic                          err_orphan_resp;

    modport arb (
        input  req_val, req_rw, req_addr, req_data,
        input  mem_req_rdy, mem_resp_val, mem_resp_data,
        output req_rdy, resp_val, resp_data,
        output mem_req_val, mem_req_rw, mem_req_addr, mem_req_data,
        output err_orphan_resp
    );

    modport client (
        output req_val, req_rw, req_addr, req_data,
        output mem_req_rdy, mem_resp_val, mem_resp_data,
        input  req_rdy, resp_val, resp_data,
        input  mem_req_val, mem_req_rw, mem_req_addr, mem_req_data,
        input  err_orphan_resp
    );

endinterface

// File: rtl/mem_tag_fifo.sv
// In-order FIFO of requester ids for loads issued to the controller; the head
// names the requester that owns the next controller response.
module mem_tag_fifo import mem_if_pkg::*; #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  req_id_t          push_id,
    input  logic             pop,
    output req_id_t          head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    req_id_t          tags [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head  = tags[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Tag storage needs no reset: it is only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) tags[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin share of one DDR controller user port between two requesters,
// with in-order steering of load responses back to the issuing requester.
module mem_req_arbiter import mem_if_pkg::*; #(
    parameter int ADDR_W          = MEM_ADDR_W,
    parameter int DATA_W          = MEM_DATA_W,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic           clk,
    input  logic           reset,
    mem_req_arbiter_if.arb bus
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic                   stage_free;
    logic                   load_ok;
    logic [NUM_MEM_REQ-1:0] elig;
    logic                   gnt_any;
    req_id_t                gnt_id;
    logic                   push;
    logic                   pop;
    req_id_t                head_id;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       load_count;

    req_id_t                last_grant;
    logic                   vld_p1;
    logic                   rw_p1;
    logic [ADDR_W-1:0]      addr_p1;
    logic [DATA_W-1:0]      data_p1;
    logic [NUM_MEM_REQ-1:0] resp_vld_p1;
    logic [DATA_W-1:0]      resp_data_p1;
    logic                   err_orphan;

    // Arbitration: load_count is the value at cycle start, so a same-cycle pop never opens a slot.
    always_comb begin
        stage_free = !vld_p1 || bus.mem_req_rdy;
        load_ok    = (load_count < CNT_W'(MAX_OUTSTANDING));
        for (int i = 0; i < NUM_MEM_REQ; i++) begin
            elig[i] = bus.req_val[i] && stage_free && (bus.req_rw[i] || load_ok);
        end
        gnt_any = |elig;
        if (&elig)        gnt_id = !last_grant;
        else if (elig[1]) gnt_id = 1'b1;
        else              gnt_id = 1'b0;
        push = gnt_any && !bus.req_rw[gnt_id];
        pop  = bus.mem_resp_val && !fifo_empty;
    end

    assign bus.req_rdy = (gnt_any && reset) ? id_onehot(gnt_id) : '0;

    mem_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .push_id (gnt_id),
        .pop     (pop),
        .head    (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (load_count)
    );

    // Stage p1: registered controller request and registered response steering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant   <= 1'b1;
            vld_p1       <= 1'b0;
            rw_p1        <= 1'b0;
            addr_p1      <= '0;
            data_p1      <= '0;
            resp_vld_p1  <= '0;
            resp_data_p1 <= '0;
            err_orphan   <= 1'b0;
        end else begin
            if (gnt_any) begin
                vld_p1     <= 1'b1;
                rw_p1      <= bus.req_rw[gnt_id];
                addr_p1    <= bus.req_addr[int'(gnt_id)*ADDR_W +: ADDR_W];
                data_p1    <= bus.req_data[int'(gnt_id)*DATA_W +: DATA_W];
                last_grant <= gnt_id;
            end else if (bus.mem_req_rdy) begin
                vld_p1 <= 1'b0;
            end
            resp_vld_p1 <= pop ? id_onehot(head_id) : '0;
            if (pop) resp_data_p1 <= bus.mem_resp_data;
            if (bus.mem_resp_val && fifo_empty) err_orphan <= 1'b1;
        end
    end

    assign bus.mem_req_val     = vld_p1;
    assign bus.mem_req_rw      = rw_p1;
    assign bus.mem_req_addr    = addr_p1;
    assign bus.mem_req_data    = data_p1;
    assign bus.resp_val        = resp_vld_p1;
    assign bus.resp_data       = resp_data_p1;
    assign bus.err_orphan_resp = err_orphan;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed sequences, a hand-computed vector table and
// random traffic, all checked against a queue-based model of the arbitration rules.
module tb_mem_req_arbiter;
    import mem_if_pkg::*;

    localparam int ADDR_W  = MEM_ADDR_W;
    localparam int DATA_W  = MEM_DATA_W;
    localparam int MAX_OUT = 4;

    typedef logic [DATA_W-1:0] word_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_req_arbiter #(
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the outstanding loads are simply a queue of requester ids.
    logic     m_vld;
    mem_req_t m_req;
    logic     m_last;
    bit       m_q[$];
    logic [1:0] m_resp;
    word_t    m_rdata;
    logic     m_err;
    logic [1:0] m_rdy;

    function automatic void model_reset();
        m_vld   = 1'b0;
        m_req   = '0;
        m_last  = 1'b1;
        m_q.delete();
        m_resp  = '0;
        m_rdata = '0;
        m_err   = 1'b0;
        m_rdy   = '0;
    endfunction

    function automatic void model_comb();
        logic [1:0] cand;
        bit free;
        free = !m_vld || bus.mem_req_rdy;
        for (int i = 0; i < 2; i++)
            cand[i] = free && bus.req_val[i] && (bus.req_rw[i] || (m_q.size() < MAX_OUT));
        m_rdy = '0;
        if (cand == 2'b11) m_rdy[!m_last] = 1'b1;
        else               m_rdy = cand;
    endfunction

    function automatic void model_seq();
        int g;
        bit had;
        had    = (m_q.size() > 0);
        m_resp = '0;
        if (bus.mem_resp_val) begin
            if (had) begin
                g         = int'(m_q.pop_front());
                m_resp[g] = 1'b1;
                m_rdata   = bus.mem_resp_data;
            end else begin
                m_err = 1'b1;
            end
        end
        if (m_rdy != 2'b00) begin
            g          = m_rdy[1] ? 1 : 0;
            m_vld      = 1'b1;
            m_req.rw   = bus.req_rw[g];
            m_req.addr = bus.req_addr[g*ADDR_W +: ADDR_W];
            m_req.data = bus.req_data[g*DATA_W +: DATA_W];
            m_last     = g[0];
            if (!m_req.rw) m_q.push_back(g[0]);
        end else if (bus.mem_req_rdy) begin
            m_vld = 1'b0;
        end
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".mem_req_val"}, word_t'(bus.mem_req_val), word_t'(m_vld));
        if (m_vld) begin
            chk({tag, ".mem_req_rw"},   word_t'(bus.mem_req_rw),   word_t'(m_req.rw));
            chk({tag, ".mem_req_addr"}, word_t'(bus.mem_req_addr), word_t'(m_req.addr));
            chk({tag, ".mem_req_data"}, bus.mem_req_data, m_req.data);
        end
        chk({tag, ".resp_val"}, word_t'(bus.resp_val), word_t'(m_resp));
        if (m_resp != 2'b00) chk({tag, ".resp_data"}, bus.resp_data, m_rdata);
        chk({tag, ".err_orphan"}, word_t'(bus.err_orphan_resp), word_t'(m_err));
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic cycle(input string tag);
        #1;
        model_comb();
        chk({tag, ".req_rdy"}, word_t'(bus.req_rdy), word_t'(m_rdy));
        @(posedge clk);
        model_seq();
        @(negedge clk);
        check_outputs(tag);
    endtask

    function automatic logic [2*DATA_W-1:0] rand_bits();
        logic [2*DATA_W-1:0] r;
        for (int i = 0; i < 2*DATA_W/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic rand_fields();
        bus.req_addr      = {ADDR_W'($urandom), ADDR_W'($urandom)};
        bus.req_data      = rand_bits();
        bus.mem_resp_data = DATA_W'(rand_bits());
    endtask

    task automatic do_reset();
        bus.req_val      = '0;
        bus.req_rw       = '0;
        bus.mem_resp_val = 1'b0;
        bus.mem_req_rdy  = 1'b1;
        reset            = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [1:0] val;
        logic [1:0] rw;
        logic       rdy;
        logic       rsp;
        logic [1:0] exp_rdy;
        logic [1:0] exp_resp;
        logic       exp_mval;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // Starting from reset, last grant = 1, MAX_OUTSTANDING = 4.
        tbl[0]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1};
        tbl[1]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1};
        tbl[2]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1};
        tbl[3]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1};
        tbl[4]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
        tbl[5]  = '{2'b11, 2'b00, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0};
        tbl[6]  = '{2'b11, 2'b00, 1'b1, 1'b1, 2'b01, 2'b10, 1'b1};
        tbl[7]  = '{2'b11, 2'b01, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1};
        tbl[8]  = '{2'b11, 2'b01, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1};
        tbl[9]  = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0};
        tbl[10] = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 2'b10, 1'b0};
        tbl[11] = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0};
        tbl[12] = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 2'b10, 1'b0};
        tbl[13] = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0};

        reset             = 1'b0;
        bus.req_val       = 2'b11;
        bus.req_rw        = 2'b00;
        bus.req_addr      = '0;
        bus.req_data      = '0;
        bus.mem_req_rdy   = 1'b1;
        bus.mem_resp_val  = 1'b0;
        bus.mem_resp_data = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst.req_rdy",      word_t'(bus.req_rdy),      word_t'(2'b00));
        chk("rst.mem_req_val",  word_t'(bus.mem_req_val),  '0);
        chk("rst.mem_req_rw",   word_t'(bus.mem_req_rw),   '0);
        chk("rst.mem_req_addr", word_t'(bus.mem_req_addr), '0);
        chk("rst.mem_req_data", bus.mem_req_data,          '0);
        chk("rst.resp_val",     word_t'(bus.resp_val),     '0);
        chk("rst.resp_data",    bus.resp_data,             '0);
        chk("rst.err_orphan",   word_t'(bus.err_orphan_resp), '0);
        bus.req_val = 2'b00;
        reset       = 1'b1;

        // Single load from port 0, answered a few cycles later.
        bus.req_val = 2'b01;
        bus.req_rw  = 2'b00;
        bus.req_addr[0 +: ADDR_W] = 26'h0000010;
        cycle("tp1.grant");
        chk("tp1.mem_req_val",  word_t'(bus.mem_req_val),  word_t'(1'b1));
        chk("tp1.mem_req_addr", word_t'(bus.mem_req_addr), word_t'(26'h0000010));
        bus.req_val = 2'b00;
        cycle("tp1.idle0");
        cycle("tp1.idle1");
        bus.mem_resp_val  = 1'b1;
        bus.mem_resp_data = word_t'(8'hA5);
        cycle("tp1.resp");
        chk("tp1.resp_val",  word_t'(bus.resp_val), word_t'(2'b01));
        chk("tp1.resp_data", bus.resp_data,         word_t'(8'hA5));
        bus.mem_resp_val = 1'b0;
        cycle("tp1.after");
        chk("tp1.resp_pulse", word_t'(bus.resp_val), '0);

        // Vector table: alternation, outstanding-load cap, store bypass, routing, orphan.
        do_reset();
        for (int k = 0; k < 14; k++) begin
            bus.req_val      = tbl[k].val;
            bus.req_rw       = tbl[k].rw;
            bus.mem_req_rdy  = tbl[k].rdy;
            bus.mem_resp_val = tbl[k].rsp;
            rand_fields();
            #1;
            chk($sformatf("tbl%0d.req_rdy", k), word_t'(bus.req_rdy), word_t'(tbl[k].exp_rdy));
            cycle($sformatf("tbl%0d", k));
            chk($sformatf("tbl%0d.resp_val", k), word_t'(bus.resp_val), word_t'(tbl[k].exp_resp));
            chk($sformatf("tbl%0d.mem_req_val", k), word_t'(bus.mem_req_val), word_t'(tbl[k].exp_mval));
        end
        chk("tbl.err_orphan", word_t'(bus.err_orphan_resp), word_t'(1'b1));

        // Store held under controller backpressure.
        do_reset();
        bus.req_val = 2'b01;
        bus.req_rw  = 2'b01;
        bus.req_addr[0 +: ADDR_W] = 26'h00003FF;
        bus.req_data[0 +: DATA_W] = '1;
        cycle("bp.grant");
        for (int k = 0; k < 5; k++) begin
            bus.mem_req_rdy = 1'b0;
            bus.req_val     = 2'b10;
            bus.req_rw      = 2'b00;
            rand_fields();
            cycle($sformatf("bp.hold%0d", k));
            chk($sformatf("bp.hold%0d.addr", k), word_t'(bus.mem_req_addr), word_t'(26'h00003FF));
            chk($sformatf("bp.hold%0d.data", k), bus.mem_req_data, '1);
        end
        bus.mem_req_rdy = 1'b1;
        cycle("bp.drain");
        bus.req_val = 2'b00;
        cycle("bp.idle0");
        cycle("bp.idle1");
        chk("bp.no_resp", word_t'(bus.resp_val), '0);

        // Asynchronous reset with loads outstanding and a response in flight.
        do_reset();
        bus.req_val = 2'b11;
        bus.req_rw  = 2'b00;
        cycle("ar.load0");
        cycle("ar.load1");
        bus.req_val = 2'b01;
        cycle("ar.load2");
        bus.req_val       = 2'b10;
        bus.mem_resp_val  = 1'b1;
        bus.mem_resp_data = word_t'(rand_bits());
        cycle("ar.resp");
        chk("ar.pre.mem_req_val", word_t'(bus.mem_req_val), word_t'(1'b1));
        chk("ar.pre.resp_val",    word_t'(bus.resp_val),    word_t'(2'b01));
        bus.mem_resp_val = 1'b0;
        bus.req_val      = 2'b11;
        #2;
        reset = 1'b0;
        #1;
        chk("ar.mem_req_val", word_t'(bus.mem_req_val), '0);
        chk("ar.resp_val",    word_t'(bus.resp_val),    '0);
        chk("ar.req_rdy",     word_t'(bus.req_rdy),     '0);
        model_reset();
        @(negedge clk);
        reset            = 1'b1;
        bus.req_val      = 2'b00;
        bus.mem_resp_val = 1'b1;
        cycle("ar.late");
        chk("ar.err_set", word_t'(bus.err_orphan_resp), word_t'(1'b1));
        bus.mem_resp_val = 1'b0;
        cycle("ar.sticky0");
        cycle("ar.sticky1");
        chk("ar.err_sticky", word_t'(bus.err_orphan_resp), word_t'(1'b1));

        // Random traffic against the model.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            bus.req_val      = 2'($urandom);
            bus.req_rw       = 2'($urandom);
            bus.mem_req_rdy  = ($urandom_range(0, 3) != 0);
            bus.mem_resp_val = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            rand_fields();
            cycle("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
